// File: rtl/intr_controller.sv
// ---------------------------------------------------------------------------
// intr_controller
//   Eight-source interrupt controller sitting on a simple I/O port bus.
//   Each IRQ line is synchronised and rising-edge detected. Edges latch into
//   PEND, and an edge on a bit that is already pending sets the sticky OVF bit.
//   An IDLE/REQ/SERVICE handshake with the control unit hands out the
//   lowest-numbered pending, unmasked source.
//
//   Register map (offset from BASE_ID):
//     +0 MASK  r/w   1 = source takes part in arbitration
//     +1 PEND  r/w1c pending sources (masked sources still latch)
//     +2 ID    r     {BUSY, 4'b0, ACTIVE_ID[2:0]}
//     +3 EOI   w     any write ends service
//     +4 OVF   r/w1c sticky overflow flags
//
// Ports
//   CLK       system clock, rising edge
//   RESET     synchronous, active-high reset
//   IRQ       asynchronous interrupt sources (rising edge significant)
//   INTR_ACK  one-cycle acknowledge from the control unit
//   IO_STRB   I/O write strobe
//   PORT_ID   I/O port address
//   OUT_PORT  I/O write data
//   INTR      registered interrupt request, high only in REQ
//   RD_DATA   combinational read data (8'h00 when not addressed)
//   RD_HIT    PORT_ID addresses one of this block's registers
// ---------------------------------------------------------------------------
module intr_controller #(
    parameter logic [7:0] BASE_ID = 8'hE0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IRQ,
    input  logic       INTR_ACK,
    input  logic       IO_STRB,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    output logic       INTR,
    output logic [7:0] RD_DATA,
    output logic       RD_HIT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sync1_q, sync2_q, hist_q;
    logic [2:0] vld_q;
    logic [7:0] mask_q, mask_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] ovf_q, ovf_d;
    logic [2:0] active_id_q, active_id_d;
    logic       intr_q;

    logic [7:0] irq_edge;
    logic [7:0] masked;
    logic [2:0] win_id;
    logic [7:0] offset;
    logic       wr_mask, wr_pend, wr_eoi, wr_ovf;
    logic [7:0] id_val;

    // Synchroniser + history. vld_q tracks how far real post-reset samples
    // have travelled down the chain; edges are only trusted once the history
    // flop holds a real sample, so a level already high at reset release
    // never looks like a fresh rising edge.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            vld_q   <= '0;
        end else begin
            sync1_q <= IRQ;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            vld_q   <= {vld_q[1:0], 1'b1};
        end
    end

    assign irq_edge = sync2_q & ~hist_q & {8{vld_q[2]}};

    // Address decode; the subtraction wraps, so any BASE_ID works.
    assign offset  = PORT_ID - BASE_ID;
    assign wr_mask = IO_STRB && (offset == 8'd0);
    assign wr_pend = IO_STRB && (offset == 8'd1);
    assign wr_eoi  = IO_STRB && (offset == 8'd3);
    assign wr_ovf  = IO_STRB && (offset == 8'd4);

    // Arbitration works on pre-edge register values, so a same-cycle
    // MASK/PEND write never changes who wins the current ACK.
    assign masked = pend_q & mask_q;

    always_comb begin
        win_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) win_id = 3'(i);
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d     = state_q;
        mask_d      = wr_mask ? OUT_PORT : mask_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        active_id_d = active_id_q;

        if (wr_pend) pend_d = pend_d & ~OUT_PORT;
        if (wr_ovf)  ovf_d  = ovf_d & ~OUT_PORT;

        unique case (state_q)
            S_IDLE: begin
                if (masked != 8'h00) state_d = S_REQ;
            end
            S_REQ: begin
                if (INTR_ACK) begin
                    active_id_d    = win_id;
                    pend_d[win_id] = 1'b0;
                    state_d        = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (wr_eoi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // New edges are applied last so they win over any same-cycle clear.
        ovf_d  = ovf_d | (irq_edge & pend_q);
        pend_d = pend_d | irq_edge;

        // Withdraw the request as soon as a write leaves nothing to serve.
        if (state_q == S_REQ && !INTR_ACK && (pend_d & mask_d) == 8'h00)
            state_d = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            active_id_q <= '0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            active_id_q <= active_id_d;
            intr_q      <= (state_d == S_REQ);
        end
    end

    assign INTR   = intr_q;
    assign id_val = {state_q == S_SERVICE, 4'b0000, active_id_q};

    always_comb begin
        RD_HIT  = 1'b1;
        RD_DATA = 8'h00;
        case (offset)
            8'd0:    RD_DATA = mask_q;
            8'd1:    RD_DATA = pend_q;
            8'd2:    RD_DATA = id_val;
            8'd3:    RD_DATA = 8'h00;
            8'd4:    RD_DATA = ovf_q;
            default: RD_HIT  = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_intr_controller.sv
// ---------------------------------------------------------------------------
// tb_intr_controller
//   Self-checking bench for intr_controller. A behavioural model keeps the
//   register file, the request/service phase and a short list of IRQ samples
//   taken at each clock edge; the model is advanced once per cycle and every
//   cycle the combinational read port and INTR are compared against it.
//   Directed scenarios come first, followed by a randomised run.
// ---------------------------------------------------------------------------
module tb_intr_controller;

    localparam logic [7:0] BASE = 8'hE0;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IRQ;
    logic       INTR_ACK;
    logic       IO_STRB;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       INTR;
    logic [7:0] RD_DATA;
    logic       RD_HIT;

    intr_controller #(.BASE_ID(BASE)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IRQ      (IRQ),
        .INTR_ACK (INTR_ACK),
        .IO_STRB  (IO_STRB),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .INTR     (INTR),
        .RD_DATA  (RD_DATA),
        .RD_HIT   (RD_HIT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef enum {PH_IDLE, PH_REQ, PH_SERVICE} phase_t;

    phase_t     m_phase;
    logic [7:0] m_mask, m_pend, m_ovf;
    int         m_active;
    logic       m_intr;
    logic [7:0] samples[$];  // IRQ values seen at the most recent edges

    function automatic logic [8:0] model_read(input logic [7:0] pid);
        int off;
        off = int'(pid) - int'(BASE);
        case (off)
            0:       return {1'b1, m_mask};
            1:       return {1'b1, m_pend};
            2:       return {1'b1, (m_phase == PH_SERVICE), 4'b0000, 3'(m_active)};
            3:       return {1'b1, 8'h00};
            4:       return {1'b1, m_ovf};
            default: return 9'h000;
        endcase
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_mask   = 8'h00;
        m_pend   = 8'h00;
        m_ovf    = 8'h00;
        m_active = 0;
        m_intr   = 1'b0;
        samples.delete();
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic [7:0] rises, new_mask, new_pend, new_ovf, avail;
        int         off, lowest;
        bit         wr;
        if (RESET) begin
            model_reset();
            return;
        end
        // A pending bit is set two edges after IRQ is first sampled high,
        // and only if the sample before that was a real post-reset low.
        rises = 8'h00;
        if (samples.size() >= 3)
            rises = samples[samples.size()-2] & ~samples[samples.size()-3];
        samples.push_back(IRQ);
        if (samples.size() > 3) void'(samples.pop_front());

        off = int'(PORT_ID) - int'(BASE);
        wr  = (IO_STRB == 1'b1);
        avail  = m_pend & m_mask;
        lowest = 0;
        for (int i = 7; i >= 0; i--) if (avail[i]) lowest = i;

        new_mask = (wr && off == 0) ? OUT_PORT : m_mask;
        new_pend = m_pend;
        if (wr && off == 1) new_pend = new_pend & ~OUT_PORT;
        new_ovf = m_ovf;
        if (wr && off == 4) new_ovf = new_ovf & ~OUT_PORT;

        case (m_phase)
            PH_IDLE: if (avail != 0) m_phase = PH_REQ;
            PH_REQ: begin
                if (INTR_ACK) begin
                    m_active = lowest;
                    new_pend[lowest] = 1'b0;
                    m_phase = PH_SERVICE;
                end else if (((new_pend | rises) & new_mask) == 0) begin
                    m_phase = PH_IDLE;
                end
            end
            PH_SERVICE: if (wr && off == 3) m_phase = PH_IDLE;
            default: m_phase = PH_IDLE;
        endcase

        m_ovf  = new_ovf | (rises & m_pend);
        m_pend = new_pend | rises;
        m_mask = new_mask;
        m_intr = (m_phase == PH_REQ);
    endtask

    // One clock cycle: check reads before the edge, INTR after it.
    task automatic step();
        logic [8:0] r;
        #1;
        r = model_read(PORT_ID);
        check("rd_hit", RD_HIT, r[8]);
        check("rd_data", RD_DATA, r[7:0]);
        model_edge();
        @(posedge CLK);
        #1;
        check("intr", INTR, m_intr);
        @(negedge CLK);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int off, input logic [7:0] data);
        IO_STRB  = 1'b1;
        PORT_ID  = BASE + 8'(off);
        OUT_PORT = data;
        step();
        IO_STRB  = 1'b0;
    endtask

    task automatic ack();
        INTR_ACK = 1'b1;
        step();
        INTR_ACK = 1'b0;
    endtask

    task automatic peek(input string tag, input int off, input logic [7:0] exp);
        IO_STRB = 1'b0;
        PORT_ID = BASE + 8'(off);
        #1;
        check(tag, RD_DATA, exp);
    endtask

    initial begin
        RESET = 1'b1; IRQ = 8'h00; INTR_ACK = 1'b0;
        IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
        model_reset();
        @(negedge CLK);
        steps(2);
        RESET = 1'b0;
        peek("rst_mask", 0, 8'h00);
        peek("rst_id", 2, 8'h00);
        check("rst_intr", INTR, 1'b0);
        steps(4);

        // Single source, latency and acknowledge
        wr(0, 8'h04);
        IRQ = 8'h04;
        step();                          // edge k samples the rise
        step();
        peek("pend_k1", 1, 8'h00);
        step();
        peek("pend_k2", 1, 8'h04);
        step();
        check("intr_k3", INTR, 1'b1);
        ack();
        peek("id_82", 2, 8'h82);
        peek("pend_after_ack", 1, 8'h00);
        wr(3, 8'h00);

        // Two simultaneous sources: priority and re-arbitration after EOI
        wr(0, 8'hFF);
        IRQ = 8'h22;
        steps(4);
        ack();
        peek("id_81", 2, 8'h81);
        peek("pend_20", 1, 8'h20);
        wr(3, 8'h5A);
        check("intr_eoi_low", INTR, 1'b0);
        step();
        check("intr_rearb", INTR, 1'b1);
        ack();
        peek("id_85", 2, 8'h85);
        wr(3, 8'h00);

        // Request withdrawn by a mask write, then restored
        IRQ = 8'h10;
        steps(4);
        check("intr_req", INTR, 1'b1);
        wr(0, 8'h00);
        check("intr_masked", INTR, 1'b0);
        peek("pend_kept", 1, 8'h10);
        wr(0, 8'hFF);
        step();
        check("intr_restore", INTR, 1'b1);
        ack();
        wr(3, 8'h00);

        // Overflow and set-beats-clear on PEND
        wr(0, 8'h00);
        IRQ = 8'h08;
        steps(4);
        peek("pend_08", 1, 8'h08);
        IRQ = 8'h00;
        steps(3);
        IRQ = 8'h08;
        steps(4);
        peek("ovf_08", 4, 8'h08);
        peek("pend_still", 1, 8'h08);
        wr(4, 8'h08);
        peek("ovf_clr", 4, 8'h00);
        IRQ = 8'h00;
        steps(3);
        IRQ = 8'h08;
        steps(2);
        wr(1, 8'h08);                    // clear lands on the same edge as the set
        peek("pend_set_wins", 1, 8'h08);
        wr(1, 8'hFF);
        wr(4, 8'hFF);
        IRQ = 8'h00;
        steps(3);

        // Reset during SERVICE with a source held high
        wr(0, 8'hFF);
        IRQ = 8'h11;
        steps(4);
        ack();
        peek("id_svc", 2, 8'h80);
        peek("pend_10", 1, 8'h10);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        peek("id_rst", 2, 8'h00);
        peek("pend_rst", 1, 8'h00);
        check("intr_rst", INTR, 1'b0);
        wr(0, 8'hFF);
        steps(8);
        peek("held_no_pend", 1, 8'h00);
        check("held_no_intr", INTR, 1'b0);

        // Out-of-range address and read-only ID
        PORT_ID = BASE + 8'd5;
        #1;
        check("oob_hit", RD_HIT, 1'b0);
        check("oob_data", RD_DATA, 8'h00);
        wr(2, 8'hFF);
        peek("id_ro", 2, 8'h00);
        IRQ = 8'h00;
        steps(4);

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) IRQ = IRQ ^ (8'h01 << $urandom_range(7));
            IO_STRB  = ($urandom_range(3) == 0);
            PORT_ID  = BASE + 8'($urandom_range(5));
            OUT_PORT = 8'($urandom);
            INTR_ACK = ($urandom_range(2) == 0);
            RESET    = ($urandom_range(80) == 0);
            step();
        end
        RESET = 1'b0; INTR_ACK = 1'b0; IO_STRB = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
